// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between a requester and the apb_slave_mem completer.
// The master modport drives the request side; the slave modport returns the response.
interface apb_slave_mem_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a small word-addressed register memory, with
// programmable wait states, error responses and a sticky protocol-violation flag.
module apb_slave_mem #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       WAIT_STATES = 0
) (
    input  logic           PCLK,
    input  logic           PRESET,
    apb_slave_mem_if.slave apb,
    output logic           proto_err
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;
    localparam logic [ADDR_W:0] END_ADDR =
        (ADDR_W+1)'(BASE_ADDR) + (ADDR_W+1)'(DEPTH * 4);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic                perr_q, perr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                setup_err_c;
    logic                complete_c;
    logic                wr_en_c;
    logic [IDX_W-1:0]    idx_c;

    // Address decode for the setup cycle; the upper bound is compared one bit wider to avoid wrap.
    always_comb begin
        setup_err_c = (apb.PADDR[1:0] != 2'b00)
                   || (apb.PADDR < BASE_ADDR)
                   || ({1'b0, apb.PADDR} >= END_ADDR);
    end

    assign idx_c      = IDX_W'((addr_q - BASE_ADDR) >> 2);
    assign complete_c = (state_q == ACCESS) && apb.PSELx && apb.PENABLE && (cnt_q == '0);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        err_d   = err_q;
        perr_d  = perr_q;
        wr_en_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (apb.PSELx && !apb.PENABLE) begin
                    state_d = ACCESS;
                    addr_d  = apb.PADDR;
                    wdata_d = apb.PWDATA;
                    write_d = apb.PWRITE;
                    err_d   = setup_err_c;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end else if (apb.PSELx && apb.PENABLE) begin
                    perr_d = 1'b1;
                end
            end
            ACCESS: begin
                if (apb.PSELx && apb.PENABLE) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        wr_en_c = write_q && !err_q;
                    end
                end else begin
                    // Requester abandoned the transfer before it completed.
                    perr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and latched transfer state
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            err_q   <= err_d;
            perr_q  <= perr_d;
        end
    end

    // Register memory, cleared by reset
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            mem_q[idx_c] <= wdata_q;
        end
    end

    assign apb.PREADY  = complete_c;
    assign apb.PSLVERR = complete_c && err_q;
    assign apb.PRDATA  = (complete_c && !write_q && !err_q) ? mem_q[idx_c] : '0;
    assign proto_err   = perr_q;
endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB3 completer (slave) holding a small word-addressed register memory.
- It is the DUT that the APB driver/monitor interface connects to: it consumes PSELx/PENABLE/PWRITE/PADDR/PWDATA and produces PRDATA/PREADY/PSLVERR.
- Supports a programmable number of wait states and error responses.
- Flags APB protocol violations seen on its inputs.

Parameters:
- ADDR_W, 32, width of PADDR.
- DATA_W, 32, width of PWDATA/PRDATA.
- DEPTH, 16, number of DATA_W-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH*4-aligned.
- WAIT_STATES, 0, number of PREADY-low cycles inserted in every access phase (0..15).

Ports:
- PCLK  input  1  clock; all state changes on rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- PSELx  input  1  slave select.
- PENABLE  input  1  access-phase strobe.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_W  byte address.
- PWDATA  input  DATA_W  write data.
- PRDATA  output  DATA_W  read data; valid only in the completing cycle.
- PREADY  output  1  transfer completes when high with PSELx&PENABLE.
- PSLVERR  output  1  error response; meaningful only with PREADY.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (PRESET=1, async): FSM to IDLE; wait counter 0; latched addr/data/dir 0; all memory words 0; PRDATA=0, PREADY=0, PSLVERR=0, proto_err=0.
- Reset mid-transfer aborts it; no memory write occurs.
- States: IDLE and ACCESS.
- IDLE -> ACCESS when PSELx=1 and PENABLE=0 (setup cycle).
  - On that edge: latch PADDR, PWRITE, PWDATA and error decode; load wait counter = WAIT_STATES.
- IDLE with PSELx=1 and PENABLE=1 is a protocol violation: set proto_err, stay IDLE, no response.
- ACCESS with PSELx=1, PENABLE=1 and counter != 0: PREADY=0, counter decrements.
- ACCESS with PSELx=1, PENABLE=1 and counter == 0: completing cycle.
  - PREADY=1 (combinational from state and counter).
  - PSLVERR = latched error.
  - PRDATA = mem[idx] for an error-free read, else 0.
  - On the edge: write mem[idx] = latched PWDATA if write and no error; FSM to IDLE.
- ACCESS with PENABLE=0 or PSELx=0 before completion: abort, set proto_err, FSM to IDLE, no write.
- Outside the completing cycle: PREADY=0, PSLVERR=0, PRDATA=0.
- Error decode at setup: error if PADDR[1:0] != 0, PADDR < BASE_ADDR, or PADDR >= BASE_ADDR + DEPTH*4.
- Word index idx = (PADDR - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
- Latched values are used throughout ACCESS; PADDR/PWDATA changes during ACCESS are ignored (not flagged).
- Back-to-back: a new setup cycle immediately after a completing cycle is accepted (FSM is IDLE then). Each transfer takes 2 + WAIT_STATES cycles.
- Read-after-write to the same word in the next transfer returns the new data.
- Latency: zero-wait read completes in the cycle after setup.

Test Plan:
- Reset, then zero-wait write 32'hDEAD_BEEF to BASE_ADDR+8, then read BASE_ADDR+8 -> each transfer PREADY=1 in the 2nd cycle; read PRDATA=32'hDEAD_BEEF; PSLVERR=0.
- WAIT_STATES=3: read BASE_ADDR+4 after reset -> PREADY low for 3 access cycles, high in the 4th; PRDATA=0.
- Write 32'h1234_5678 to BASE_ADDR+DEPTH*4, then write to BASE_ADDR+2 -> each completes with PREADY=1, PSLVERR=1; read of words 0..DEPTH-1 all return 0.
- Back-to-back writes of 1, 2, 3 to words 0, 1, 2 with no idle cycles, then reads -> 2-cycle spacing, data 1, 2, 3 returned.
- Drop PSELx in ACCESS with WAIT_STATES=2 during a write of 32'hAAAA_AAAA to word 5 -> proto_err=1, word 5 reads 0.
- Assert PRESET during ACCESS -> immediate PREADY=0, PSLVERR=0, proto_err=0, memory cleared.
